// File: rtl/mesi_pkg.sv
// Shared encodings for the MESI cache controllers and the shared-bus responder.
// The controller FSM state type lives here so tools and benches can name states.
package mesi_pkg;

  typedef enum logic [1:0] {
    BUS_NONE    = 2'd0,
    BUS_RD_MISS = 2'd1,
    BUS_WR_MISS = 2'd2,
    BUS_INVAL   = 2'd3
  } bus_msg_e;

  typedef enum logic [1:0] {
    MEM_NONE   = 2'd0,
    MEM_READ   = 2'd1,
    MEM_WRBACK = 2'd2,
    MEM_RSVD   = 2'd3
  } mem_msg_e;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_state_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WB    = 3'd1,
    ST_SNOOP = 3'd2,
    ST_FLUSH = 3'd3,
    ST_MEMRD = 3'd4,
    ST_DONE  = 3'd5
  } ctrl_state_e;

  function automatic logic [1:0] one_hot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mesi_bus_ctrl_if.sv
// Bus bundle between the two cache controllers (master) and the bus responder (slave).
interface mesi_bus_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);

  logic [1:0]        c0_bus_req;
  logic [1:0]        c0_mem_req;
  logic [ADDR_W-1:0] c0_addr;
  logic [DATA_W-1:0] c0_wdata;
  logic              c0_snoop_hit;
  logic              c0_snoop_dirty;

  logic [1:0]        c1_bus_req;
  logic [1:0]        c1_mem_req;
  logic [ADDR_W-1:0] c1_addr;
  logic [DATA_W-1:0] c1_wdata;
  logic              c1_snoop_hit;
  logic              c1_snoop_dirty;

  logic [1:0]        c0_snoop;
  logic [1:0]        c1_snoop;
  logic [ADDR_W-1:0] snoop_addr;
  logic [1:0]        grant;
  logic [1:0]        done;
  logic [DATA_W-1:0] rdata;
  logic              shared;
  logic              busy;

  modport master (
    output c0_bus_req, c0_mem_req, c0_addr, c0_wdata, c0_snoop_hit, c0_snoop_dirty,
    output c1_bus_req, c1_mem_req, c1_addr, c1_wdata, c1_snoop_hit, c1_snoop_dirty,
    input  c0_snoop, c1_snoop, snoop_addr, grant, done, rdata, shared, busy
  );

  modport slave (
    input  c0_bus_req, c0_mem_req, c0_addr, c0_wdata, c0_snoop_hit, c0_snoop_dirty,
    input  c1_bus_req, c1_mem_req, c1_addr, c1_wdata, c1_snoop_hit, c1_snoop_dirty,
    output c0_snoop, c1_snoop, snoop_addr, grant, done, rdata, shared, busy
  );

endinterface

// File: rtl/mesi_mem.sv
// Small backing memory: clearable register array plus a fixed-latency ready strobe.
module mesi_mem #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 4,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              op_active,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [CNT_W-1:0]  cnt_reg;

  // Counter reloads whenever no access is running, so each access gets a full MEM_LAT window.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_reg <= CNT_W'(MEM_LAT - 1);
    end else if (!op_active || ready) begin
      cnt_reg <= CNT_W'(MEM_LAT - 1);
    end else begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign ready = op_active && (cnt_reg == '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/mesi_bus_ctrl.sv
// Two-cache MESI bus responder: round-robin arbitration, snoop broadcast,
// dirty-line flush into memory, and fixed-latency memory reads.
module mesi_bus_ctrl
  import mesi_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 4,
  parameter int MEM_LAT = 2
) (
  input  logic           clock,
  input  logic           resetn,
  mesi_bus_ctrl_if.slave bus
);

  logic [1:0]        bus_req_v   [2];
  logic [1:0]        mem_req_v   [2];
  logic [ADDR_W-1:0] addr_v      [2];
  logic [DATA_W-1:0] wdata_v     [2];
  logic              hit_v       [2];
  logic              dirty_v     [2];
  logic [1:0]        req;
  logic              win;

  ctrl_state_e       state_reg, state_next;
  logic              owner_reg;
  logic              rr_ptr_reg;
  bus_msg_e          bus_code_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] flush_data_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              shared_reg;
  logic              other;

  logic              mem_active;
  logic              mem_we;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign bus_req_v[0] = bus.c0_bus_req;
  assign bus_req_v[1] = bus.c1_bus_req;
  assign mem_req_v[0] = bus.c0_mem_req;
  assign mem_req_v[1] = bus.c1_mem_req;
  assign addr_v[0]    = bus.c0_addr;
  assign addr_v[1]    = bus.c1_addr;
  assign wdata_v[0]   = bus.c0_wdata;
  assign wdata_v[1]   = bus.c1_wdata;
  assign hit_v[0]     = bus.c0_snoop_hit;
  assign hit_v[1]     = bus.c1_snoop_hit;
  assign dirty_v[0]   = bus.c0_snoop_dirty;
  assign dirty_v[1]   = bus.c1_snoop_dirty;

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign req[gi] = (bus_req_v[gi] != BUS_NONE) || (mem_req_v[gi] == MEM_WRBACK);
  end

  // Pointer only matters on a tie; a lone requester always wins.
  assign win   = (req[0] && req[1]) ? rr_ptr_reg : req[1];
  assign other = ~owner_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req != 2'b00) begin
          state_next = (mem_req_v[win] == MEM_WRBACK) ? ST_WB : ST_SNOOP;
        end
      end
      ST_WB: begin
        if (mem_ready) begin
          state_next = (bus_code_reg != BUS_NONE) ? ST_SNOOP : ST_DONE;
        end
      end
      ST_SNOOP: begin
        if (bus_code_reg == BUS_INVAL) begin
          state_next = ST_DONE;
        end else if (dirty_v[other]) begin
          state_next = ST_FLUSH;
        end else begin
          state_next = ST_MEMRD;
        end
      end
      ST_FLUSH: if (mem_ready) state_next = ST_DONE;
      ST_MEMRD: if (mem_ready) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= 1'b0;
      rr_ptr_reg     <= 1'b0;
      bus_code_reg   <= BUS_NONE;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      flush_data_reg <= '0;
      rdata_reg      <= '0;
      shared_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (req != 2'b00) begin
            owner_reg    <= win;
            bus_code_reg <= bus_msg_e'(bus_req_v[win]);
            addr_reg     <= addr_v[win];
            wdata_reg    <= wdata_v[win];
          end
        end
        ST_SNOOP: begin
          shared_reg     <= hit_v[other];
          flush_data_reg <= wdata_v[other];
          if (bus_code_reg == BUS_INVAL) rdata_reg <= '0;
        end
        ST_FLUSH: if (mem_ready) rdata_reg <= flush_data_reg;
        ST_MEMRD: if (mem_ready) rdata_reg <= mem_rdata;
        ST_DONE:  rr_ptr_reg <= other;
        default: ;
      endcase
    end
  end

  assign mem_active = (state_reg == ST_WB) || (state_reg == ST_FLUSH) || (state_reg == ST_MEMRD);
  assign mem_we     = mem_ready && ((state_reg == ST_WB) || (state_reg == ST_FLUSH));
  assign mem_wdata  = (state_reg == ST_FLUSH) ? flush_data_reg : wdata_reg;

  mesi_mem #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MEM_LAT (MEM_LAT)
  ) u_mem (
    .clock     (clock),
    .resetn    (resetn),
    .op_active (mem_active),
    .we        (mem_we),
    .waddr     (addr_reg),
    .wdata     (mem_wdata),
    .raddr     (addr_reg),
    .rdata     (mem_rdata),
    .ready     (mem_ready)
  );

  assign bus.busy       = (state_reg != ST_IDLE);
  assign bus.grant      = (state_reg != ST_IDLE) ? one_hot2(owner_reg) : 2'b00;
  assign bus.done       = (state_reg == ST_DONE) ? one_hot2(owner_reg) : 2'b00;
  assign bus.c0_snoop   = ((state_reg == ST_SNOOP) && owner_reg)  ? bus_code_reg : BUS_NONE;
  assign bus.c1_snoop   = ((state_reg == ST_SNOOP) && !owner_reg) ? bus_code_reg : BUS_NONE;
  assign bus.snoop_addr = addr_reg;
  assign bus.rdata      = rdata_reg;
  assign bus.shared     = shared_reg;

endmodule

// File: tb/tb_mesi_bus_ctrl.sv
// Randomized bench for mesi_bus_ctrl against a transaction-level model of the
// memory contents, arbitration order and per-transaction latency.
module tb_mesi_bus_ctrl;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 4;
  localparam int MEM_LAT = 2;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  mesi_bus_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

  mesi_bus_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MEM_LAT (MEM_LAT)
  ) dut (
    .clock  (clk),
    .resetn (resetn),
    .bus    (ifc)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bit [DATA_W-1:0] mem_m [16];
  int              ptr_m;

  bit [1:0]        p_code  [2];
  bit [1:0]        p_mem   [2];
  bit [ADDR_W-1:0] p_addr  [2];
  bit [DATA_W-1:0] p_wdata [2];
  bit              p_hit   [2];
  bit              p_dirty [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive();
    ifc.c0_bus_req     = p_code[0];
    ifc.c0_mem_req     = p_mem[0];
    ifc.c0_addr        = p_addr[0];
    ifc.c0_wdata       = p_wdata[0];
    ifc.c0_snoop_hit   = p_hit[0];
    ifc.c0_snoop_dirty = p_dirty[0];
    ifc.c1_bus_req     = p_code[1];
    ifc.c1_mem_req     = p_mem[1];
    ifc.c1_addr        = p_addr[1];
    ifc.c1_wdata       = p_wdata[1];
    ifc.c1_snoop_hit   = p_hit[1];
    ifc.c1_snoop_dirty = p_dirty[1];
  endtask

  task automatic set_req(input int i, input bit [1:0] code, input bit [1:0] mem,
                         input bit [ADDR_W-1:0] addr, input bit [DATA_W-1:0] wdata,
                         input bit hit, input bit dirty);
    p_code[i]  = code;
    p_mem[i]   = mem;
    p_addr[i]  = addr;
    p_wdata[i] = wdata;
    p_hit[i]   = hit;
    p_dirty[i] = dirty;
  endtask

  function automatic bit is_req(input int i);
    return (p_code[i] != 2'd0) || (p_mem[i] == 2'd2);
  endfunction

  function automatic logic [1:0] snoop_of(input int i);
    return (i != 0) ? ifc.c1_snoop : ifc.c0_snoop;
  endfunction

  // One transaction: predict from the model, wait for done, compare, then retire the owner.
  task automatic serve_one();
    int o, oth, exp_lat, start, lat, s_cnt, own_bad;
    logic [1:0] s_val;
    bit got, wb;
    bit [1:0] code;
    bit [ADDR_W-1:0] addr;
    bit [DATA_W-1:0] exp_rd;
    bit exp_sh;

    if (is_req(0) && is_req(1)) o = ptr_m;
    else o = is_req(1) ? 1 : 0;
    oth  = 1 - o;
    code = p_code[o];
    wb   = (p_mem[o] == 2'd2);
    addr = p_addr[o];

    exp_lat = 2 + (wb ? MEM_LAT : 0) + ((code != 2'd0) ? (1 + ((code == 2'd3) ? 0 : MEM_LAT)) : 0);
    if (wb) mem_m[addr] = p_wdata[o];
    exp_sh = p_hit[oth];
    exp_rd = '0;
    if (code == 2'd3) begin
      exp_rd = '0;
    end else if (code != 2'd0) begin
      if (p_dirty[oth]) begin
        mem_m[addr] = p_wdata[oth];
        exp_rd      = p_wdata[oth];
      end else begin
        exp_rd = mem_m[addr];
      end
    end

    start   = cyc;
    got     = 1'b0;
    s_cnt   = 0;
    s_val   = 2'd0;
    own_bad = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (snoop_of(oth) != 2'd0) begin
        s_cnt++;
        s_val = snoop_of(oth);
      end
      if (snoop_of(o) != 2'd0) own_bad++;
      if (ifc.done != 2'b00) got = 1'b1;
      else tick();
    end
    lat = cyc - start + 1;

    $display("txn owner=%0d code=%0d wb=%0d addr=%0d lat=%0d rdata=%0d shared=%0d",
             o, code, wb, addr, lat, ifc.rdata, ifc.shared);
    check_val("done_seen", 32'(got), 32'd1);
    check_val("done_owner", 32'(ifc.done), (o != 0) ? 32'd2 : 32'd1);
    check_val("grant", 32'(ifc.grant), (o != 0) ? 32'd2 : 32'd1);
    check_val("busy", 32'(ifc.busy), 32'd1);
    check_val("latency", 32'(lat), 32'(exp_lat));
    check_val("snoop_addr", 32'(ifc.snoop_addr), 32'(addr));
    check_val("snoop_cycles", 32'(s_cnt), (code != 2'd0) ? 32'd1 : 32'd0);
    check_val("owner_snoop", 32'(own_bad), 32'd0);
    if (code != 2'd0) begin
      check_val("snoop_code", 32'(s_val), 32'(code));
      check_val("rdata", 32'(ifc.rdata), 32'(exp_rd));
      check_val("shared", 32'(ifc.shared), 32'(exp_sh));
    end

    p_code[o] = 2'd0;
    p_mem[o]  = 2'd0;
    drive();
    ptr_m = oth;
    tick();
    check_val("idle_after_done", 32'({ifc.busy, ifc.done}), 32'd0);
  endtask

  task automatic serve_all();
    drive();
    for (int g = 0; g < 4 && (is_req(0) || is_req(1)); g++) begin
      serve_one();
    end
  endtask

  task automatic rand_req(input int i, input bit active);
    bit [1:0] code, mem;
    bit hit, dirty;
    hit   = 1'($urandom_range(0, 1));
    dirty = hit & 1'($urandom_range(0, 1));
    mem   = 2'($urandom_range(0, 2));
    if (mem == 2'd2) mem = 2'd3;
    code  = 2'd0;
    if (active) begin
      code = 2'($urandom_range(0, 3));
      if (code == 2'd0 || $urandom_range(0, 3) == 0) mem = 2'd2;
    end
    set_req(i, code, mem, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), hit, dirty);
  endtask

  task automatic clear_reqs();
    set_req(0, 2'd0, 2'd0, '0, '0, 1'b0, 1'b0);
    set_req(1, 2'd0, 2'd0, '0, '0, 1'b0, 1'b0);
    drive();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int act;
    resetn = 1'b0;
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    ptr_m = 0;
    clear_reqs();
    tick();
    tick();
    check_val("rst_busy", 32'(ifc.busy), 32'd0);
    check_val("rst_grant", 32'(ifc.grant), 32'd0);
    check_val("rst_done", 32'(ifc.done), 32'd0);
    check_val("rst_rdata", 32'(ifc.rdata), 32'd0);
    check_val("rst_shared", 32'(ifc.shared), 32'd0);
    check_val("rst_snoop0", 32'(ifc.c0_snoop), 32'd0);
    check_val("rst_snoop1", 32'(ifc.c1_snoop), 32'd0);
    check_val("rst_saddr", 32'(ifc.snoop_addr), 32'd0);
    resetn = 1'b1;
    tick();

    // Directed scenarios first, then random traffic.
    clear_reqs();
    set_req(0, 2'd0, 2'd2, 4'd5, 4'd9, 1'b0, 1'b0);
    serve_all();
    set_req(0, 2'd1, 2'd1, 4'd5, 4'd0, 1'b0, 1'b0);
    serve_all();
    set_req(0, 2'd0, 2'd0, 4'd0, 4'hA, 1'b1, 1'b1);
    set_req(1, 2'd2, 2'd0, 4'd3, 4'd0, 1'b0, 1'b0);
    serve_all();
    clear_reqs();
    set_req(0, 2'd1, 2'd1, 4'd3, 4'd0, 1'b0, 1'b0);
    serve_all();
    clear_reqs();
    set_req(0, 2'd3, 2'd0, 4'd2, 4'd0, 1'b0, 1'b0);
    set_req(1, 2'd0, 2'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    serve_all();
    clear_reqs();
    set_req(1, 2'd1, 2'd2, 4'd7, 4'd6, 1'b0, 1'b0);
    serve_all();
    clear_reqs();
    set_req(1, 2'd1, 2'd1, 4'd1, 4'd0, 1'b0, 1'b0);
    serve_all();

    // Abort a clean read while it sits in its memory-read phase.
    clear_reqs();
    set_req(0, 2'd1, 2'd1, 4'd5, 4'd0, 1'b0, 1'b0);
    drive();
    tick();
    tick();
    check_val("pre_abort_busy", 32'(ifc.busy), 32'd1);
    resetn = 1'b0;
    #1;
    check_val("abort_done", 32'(ifc.done), 32'd0);
    check_val("abort_busy", 32'(ifc.busy), 32'd0);
    check_val("abort_grant", 32'(ifc.grant), 32'd0);
    tick();
    check_val("abort_done_hold", 32'(ifc.done), 32'd0);
    check_val("abort_rdata", 32'(ifc.rdata), 32'd0);
    clear_reqs();
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    ptr_m  = 0;
    resetn = 1'b1;
    tick();

    // Simultaneous pairs right after reset: cache 0 then cache 1, repeatedly.
    for (int n = 0; n < 2; n++) begin
      set_req(0, 2'd1, 2'd1, 4'd5, 4'd3, 1'b0, 1'b0);
      set_req(1, 2'd1, 2'd1, 4'd7, 4'd4, 1'b0, 1'b0);
      serve_all();
    end

    for (int r = 0; r < 150; r++) begin
      repeat ($urandom_range(0, 2)) tick();
      act = $urandom_range(1, 3);
      rand_req(0, act[0]);
      rand_req(1, act[1]);
      serve_all();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mesi_bus_ctrl.md
Name: mesi_bus_ctrl

Overview:
- Shared-bus and memory-side responder for the MESI coherence design.
- Serves two MESI cache controllers. Each presents a bus message (read miss, write miss, invalidate) and a memory message (read, writeback).
- Arbitrates round-robin, broadcasts the winner's message as a snoop to the other cache, gets flushed data from a dirty snooper, and services a small internal memory with fixed latency.
- Returns data, a shared flag and a done pulse to the requester.

Parameters:
- ADDR_W, 4, line address width; memory depth is 2**ADDR_W.
- DATA_W, 4, data word width.
- MEM_LAT, 2, memory access cycles per read or write (must be at least 1).

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- c0_bus_req  in  2  cache 0 bus message: 0 NONE, 1 RD_MISS, 2 WR_MISS, 3 INVAL.
- c0_mem_req  in  2  cache 0 memory message: 0 NONE, 1 READ, 2 WRBACK, 3 reserved (treated as NONE).
- c0_addr  in  ADDR_W  cache 0 line address.
- c0_wdata  in  DATA_W  cache 0 writeback / flush data.
- c0_snoop_hit  in  1  cache 0 holds the snooped line.
- c0_snoop_dirty  in  1  cache 0 holds the snooped line in M.
- c1_bus_req, c1_mem_req, c1_addr, c1_wdata, c1_snoop_hit, c1_snoop_dirty: same as cache 0, for cache 1.
- c0_snoop  out  2  bus message broadcast to cache 0; same encoding as bus_req.
- c1_snoop  out  2  bus message broadcast to cache 1.
- snoop_addr  out  ADDR_W  address of the current transaction.
- grant  out  2  one-hot owner; bit i means cache i.
- done  out  2  one-hot one-cycle completion pulse.
- rdata  out  DATA_W  line data for the requester; valid while done is high.
- shared  out  1  other cache held the line; valid while done is high. Requester uses it to choose S or E.
- busy  out  1  a transaction is in progress.

Behaviour:
- Reset (resetn=0, async):
  - state IDLE, all outputs 0, round-robin pointer favours cache 0.
  - All memory words cleared to 0.
  - Reset mid-transaction aborts it; no done pulse is issued.
- Request and handshake:
  - Cache i requests when bus_req!=NONE or mem_req==WRBACK.
  - It holds req, addr and wdata stable until done[i].
  - It must drop or change its request the cycle after done.
- FSM states: IDLE, WB, SNOOP, FLUSH, MEMRD, DONE.
- IDLE:
  - If any cache requests, grant the one favoured by the pointer. A lone requester wins regardless of pointer.
  - Latch codes, addr and wdata; assert grant and busy next cycle.
  - Next state is WB if mem_req==WRBACK, else SNOOP.
- WB:
  - Writes latched wdata to mem[addr] for MEM_LAT cycles; the write commits on the last cycle.
  - Then SNOOP if bus_req!=NONE, else DONE.
- SNOOP (1 cycle):
  - Drive latched bus code on the other cache's snoop port; the owner's snoop port stays NONE.
  - Drive snoop_addr.
  - Sample the other cache's hit/dirty at the end of the cycle; shared <= hit.
  - RD_MISS/WR_MISS with dirty -> FLUSH.
  - RD_MISS/WR_MISS clean -> MEMRD.
  - INVAL -> DONE; no memory access, dirty ignored, rdata 0.
- FLUSH:
  - MEM_LAT cycles.
  - Writes the snooper's wdata to mem[addr] and captures it as rdata.
  - Snoop port returns to NONE after SNOOP.
  - Then DONE.
- MEMRD: MEM_LAT cycles; rdata <= mem[addr]; then DONE.
- DONE (1 cycle):
  - done[owner]=1; rdata and shared valid.
  - Next cycle: grant, busy and done go to 0, state IDLE.
  - Pointer moves to favour the non-owner.
- Latency from the first IDLE cycle seeing a request to done:
  - clean read: 2+MEM_LAT+1 cycles (MEM_LAT=2 gives 5; done in cycle 4 counting from 0).
  - INVAL: 3.
  - WRBACK alone: MEM_LAT+2.
- Boundaries:
  - Simultaneous requests resolve by pointer; the loser waits and is served next with no starvation.
  - Requests arriving while busy are ignored until IDLE.
  - Addresses wrap naturally within 2**ADDR_W.
  - rdata/shared hold their last value outside DONE.

Decomposition:
- Package mesi_pkg holds:
  - bus message enum (NONE, RD_MISS, WR_MISS, INVAL);
  - memory message enum (NONE, READ, WRBACK);
  - MESI state encoding (I=0, S=1, E=2, M=3), shared with the cache FSM.
- One sub-module, mesi_mem: 2**ADDR_W x DATA_W register array with async clear, one write port, one read port, and a MEM_LAT down-counter giving a ready strobe.

Test Plan:
- Cache0 RD_MISS addr 5, mem[5]=9, cache1 hit=0 -> c1_snoop=1 for one cycle; done[0] in cycle 4; rdata=9, shared=0.
- Cache1 WR_MISS addr 3, cache0 hit=1, dirty=1, c0_wdata=0xA -> FLUSH; done[1]; rdata=0xA, shared=1; a later read of addr 3 returns 0xA.
- Cache0 INVAL addr 2, cache1 hit=1 -> c1_snoop=3; done[0] 3 cycles after request; memory unchanged.
- Both caches request RD_MISS in the same cycle after reset -> cache0 served first, then cache1; third simultaneous pair -> cache0 again.
- Cache1 WRBACK addr 7, data 6, plus RD_MISS addr 1 -> mem[7]=6 committed before the snoop; done[1] after 2*MEM_LAT+3 cycles.
- resetn low during MEMRD -> outputs 0 immediately, no done pulse, memory cleared, next request served normally.
